// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
// Multi-cycle execution unit for the EX stage of the multi-cycle datapath.
// Logic, arithmetic and compare operations finish in one cycle. Shifts move
// one bit position per clock, so one narrow shifter is enough.
// Requests and results both use a valid/ready handshake.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake (in_ready is high only in IDLE)
//   ALUControl         4-bit operation code from the ALU control decoder
//   a, b               operands; b is the operand that gets shifted
//   shamt              immediate shift amount for SLL/SRL/SRA
//   out_valid/out_ready result handshake (out_valid is high only in DONE)
//   result, zero, err  registered result, zero/branch flag, undefined-code flag
//
// WIDTH must be 32 because the shift amount is 5 bits.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] work;
    logic [4:0]       count;
    logic             shift_left;
    logic             shift_arith;

    logic             is_shift;
    logic             dec_left;
    logic             dec_arith;
    logic [4:0]       dec_count;

    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_err;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] accept_shifted;
    logic [WIDTH-1:0] work_shifted;

    // One-position shifter shared by the accept path and the SHIFT loop.
    // Arithmetic right shifts replicate the current top bit.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             arith
    );
        if (left)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {arith & v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    // Decode which codes are shifts, their direction/fill and where the
    // count comes from (shamt for the immediate forms, a[4:0] for the
    // variable forms).
    always_comb begin
        is_shift  = 1'b0;
        dec_left  = 1'b0;
        dec_arith = 1'b0;
        dec_count = shamt;
        case (ALUControl)
            4'b1001: begin is_shift = 1'b1; dec_left  = 1'b1; end
            4'b1010: begin is_shift = 1'b1; end
            4'b1101: begin is_shift = 1'b1; dec_arith = 1'b1; end
            4'b0011: begin is_shift = 1'b1; dec_left  = 1'b1; dec_count = a[4:0]; end
            4'b0100: begin is_shift = 1'b1; dec_count = a[4:0]; end
            4'b0101: begin is_shift = 1'b1; dec_arith = 1'b1; dec_count = a[4:0]; end
            default: ;
        endcase
    end

    // Single-cycle operations. BNE reuses the subtractor but reports
    // inequality on zero so the branch logic can use the flag directly.
    always_comb begin
        diff       = a - b;
        alu_result = '0;
        alu_err    = 1'b0;
        case (ALUControl)
            4'b0000: alu_result = a & b;
            4'b0001: alu_result = a | b;
            4'b1011: alu_result = a ^ b;
            4'b1100: alu_result = ~(a | b);
            4'b0010: alu_result = a + b;
            4'b0110: alu_result = diff;
            4'b0111: alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1111: alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1000: alu_result = diff;
            4'b1110: alu_err    = 1'b1;
            default: ;
        endcase
        if (ALUControl == 4'b1000)
            alu_zero = (a != b);
        else
            alu_zero = (alu_result == '0);
    end

    assign accept_shifted = shift_one(b, dec_left, dec_arith);
    assign work_shifted   = shift_one(work, shift_left, shift_arith);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. The first shift position is taken on the accept
    // edge itself, so a count of n spends n-1 cycles in SHIFT and the
    // result appears n cycles after accept. Counts 0 and 1 skip SHIFT.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (dec_count > 5'd1))
                        next_state = SHIFT;
                    else
                        next_state = DONE;
                end
            end
            SHIFT: begin
                if (count == 5'd1)
                    next_state = DONE;
            end
            DONE: begin
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are decoded straight from the state register.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath registers. result/zero/err only change on a load, so they
    // stay stable through DONE and after leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            zero        <= 1'b0;
            err         <= 1'b0;
            work        <= '0;
            count       <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_shift) begin
                            result <= alu_result;
                            zero   <= alu_zero;
                            err    <= alu_err;
                        end else if (dec_count == 5'd0) begin
                            result <= b;
                            zero   <= (b == '0);
                            err    <= 1'b0;
                        end else if (dec_count == 5'd1) begin
                            result <= accept_shifted;
                            zero   <= (accept_shifted == '0);
                            err    <= 1'b0;
                        end else begin
                            work        <= accept_shifted;
                            count       <= dec_count - 5'd1;
                            shift_left  <= dec_left;
                            shift_arith <= dec_arith;
                        end
                    end
                end
                SHIFT: begin
                    work  <= work_shifted;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        result <= work_shifted;
                        zero   <= (work_shifted == '0);
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

- Multi-cycle execution unit. It consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands and a shift amount.
- Logic, arithmetic and compare ops complete in one cycle. Shifts are iterative, one bit position per clock, to save area.
- Sits in the EX stage of the multi-cycle datapath, between the operand registers and the ALUOut/branch logic.
- Uses a valid/ready handshake on both input and output.

## Interface
Parameters:
- WIDTH, 32, operand/result width. Must be 32; the shift amount is 5 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; equals (state==IDLE)
- ALUControl  in  4  operation code (encoding in Operation)
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate); this is the operand that gets shifted
- shamt  in  5  shift amount for SLL/SRL/SRA
- out_valid  out  1  result available; equals (state==DONE)
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  registered zero/branch flag
- err  out  1  registered flag: code was undefined

## Operation
States:
- IDLE: in_ready=1.
- SHIFT: iterative shift in progress.
- DONE: out_valid=1; result, zero and err are held stable.

Accept occurs on an edge with in_valid && in_ready. ALUControl, a, b and shamt are sampled only at accept.

Encoding:
- 0000 AND, 0001 OR, 1011 XOR, 1100 NOR.
- 0010 ADD, 0110 SUB. Both modulo 2^WIDTH, no overflow trap.
- 0111 SLT (signed), 1111 SLTU (unsigned). Result is 1 when a<b, else 0.
- 1000 BNE compare: result = a-b; zero = (a != b).
- Shifts with count from shamt: 1001 SLL, 1010 SRL, 1101 SRA.
- Shifts with count from a[4:0]: 0011 SLLV, 0100 SRLV, 0101 SRAV.
- 1110 undefined: result = 0, err = 1, zero = 1.

Flags:
- For every code except 1000: zero = (result == 0).
- err = 0 for every defined code.

Non-shift op at accept: compute, load result/zero/err, go to DONE.

Shift op at accept, with n = shift count:
- n=0: result = b, go to DONE.
- n>0: load work reg = b, counter = n, go to SHIFT.

Each SHIFT cycle:
- Shift work reg by one position: logical fill 0; arithmetic fill with bit WIDTH-1 of work reg.
- Decrement counter.
- On the edge where counter goes 1→0, load result and zero and go to DONE.

DONE → IDLE on an edge with out_ready=1.

Boundary rules:
- in_valid is ignored outside IDLE (no queueing).
- out_ready is ignored outside DONE.
- Reset at any time, including mid-SHIFT: state returns to IDLE immediately and the partial operation is discarded.

## Timing
Reset values:
- in_ready = 1 once in IDLE.
- out_valid = 0, result = 0, zero = 0, err = 0.
- Counter and work reg = 0.

Latency, counted from the accept edge to the first cycle with out_valid high:
- Non-shift ops and zero-count shifts: 1 cycle.
- Shifts with count n≥1: n cycles.
- Maximum 31 cycles.

Handshake:
- in_ready drops the cycle after accept and stays low through SHIFT and DONE.
- DONE lasts until out_ready is sampled high: at least 1 cycle, no upper bound.
- result, zero and err are stable whenever out_valid=1, and are held after the DONE exit until the next load.
- in_ready returns high the cycle after out_ready is sampled high in DONE.
- Peak throughput is one op per 2 cycles.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Test plan
- Reset then ADD a=7, b=5 with out_ready=1 → out_valid high 1 cycle after accept, result=12, zero=0, err=0. in_ready high again the following cycle.
- SUB a=b=5 → result=0, zero=1. BNE a=b=5 → zero=0. BNE a=5, b=6 → result=0xFFFFFFFF, zero=1.
- SRA b=0x80000000, shamt=4 → in_ready low throughout, out_valid exactly 4 cycles after accept, result=0xF8000000. SRL with the same inputs → 0x08000000.
- SLLV a=33, b=1 (count 1) → result=2, latency 1. SLL shamt=0, b=0x1234 → result=0x1234, latency 1.
- SLT a=0xFFFFFFFF, b=1 → result=1. SLTU with the same operands → 0, zero=1. Code 1110 → result=0, err=1. in_valid pulsed during SHIFT → ignored.
- Two scenarios:
  - rst_n low on the 3rd cycle of SRL shamt=20 → out_valid=0, result=0 immediately; after release a fresh ADD completes correctly.
  - out_ready held low 5 cycles in DONE → result stable and out_valid high for all 5 cycles.
